basic_pulse_gate_n: RTL and testbench

BASIC_PULSE_GATE_N -- requirements
Module: basic_pulse_gate_n

---
 rtl/basic_pulse_gate_n.sv | 153 +++++++++++++++
 tb/tb_basic_pulse_gate_n.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_pulse_gate_n.sv
// ---------------------------------------------------------------------------
// basic_pulse_gate_n
// Toggle-encoded (SFQ-style) N-input logic gate.  Data inputs and the logical
// clock are level-toggle encoded: every level change is one pulse.  Arrivals
// within a logical clock window set per-input flags; a logical clock pulse
// evaluates the flags (XOR / OR / AND), opens a fresh window, and schedules an
// output toggle OUT_DELAY clk cycles later when the result is 1.
//
// Ports
//   clk        in   sampling clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   a_i        in   N toggle-encoded data inputs
//   sfq_clk    in   toggle-encoded logical clock
//   out        out  toggle-encoded result
//   out_pulse  out  one-cycle strobe coincident with each toggle of out
//   viol       out  one-cycle strobe: arrival coincident with logical clock
//   dbl        out  one-cycle strobe: repeated arrival on one input in a window
//   viol_cnt   out  saturating count of viol strobes
//   ready      out  high once the BEGIN_CYCLES arming period has elapsed
// ---------------------------------------------------------------------------
module basic_pulse_gate_n #(
   parameter int N            = 2,
   parameter int MODE         = 0,
   parameter int OUT_DELAY    = 1,
   parameter int BEGIN_CYCLES = 8,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     a_i,
   input  logic             sfq_clk,
   output logic             out,
   output logic             out_pulse,
   output logic             viol,
   output logic             dbl,
   output logic [CNT_W-1:0] viol_cnt,
   output logic             ready
);

   localparam int ARM_W = $clog2(BEGIN_CYCLES + 2);
   // Arming ends on the BEGIN_CYCLES-th posedge after release; the counter
   // holds the number of posedges already seen, so that edge sees BEGIN_CYCLES-1.
   localparam logic [ARM_W-1:0] ARM_LAST =
      ARM_W'((BEGIN_CYCLES > 0) ? (BEGIN_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      ST_ARM  = 2'd0,
      ST_IDLE = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [N-1:0]           a_q;
   logic                   sfq_q;
   logic [N-1:0]           flags_q, flags_d;
   logic [OUT_DELAY-1:0]   pipe_q, pipe_d;
   logic [ARM_W-1:0]       arm_cnt_q;
   logic                   out_q, out_pulse_q, viol_q, dbl_q, ready_q;
   logic [CNT_W-1:0]       viol_cnt_q;

   logic [N-1:0]           arr;
   logic                   clk_det;
   logic                   any_arr;
   logic                   res;
   logic                   viol_d;
   logic                   dbl_d;

   // Gate function over the window flags; unknown MODE values fall back to parity.
   function automatic logic eval_gate(input logic [N-1:0] f);
      case (MODE)
         1:       return |f;
         2:       return &f;
         default: return ^f;
      endcase
   endfunction

   always_comb begin
      arr      = a_i ^ a_q;
      clk_det  = sfq_clk ^ sfq_q;
      any_arr  = |arr;
      state_d  = state_q;
      flags_d  = flags_q;
      res      = 1'b0;
      viol_d   = 1'b0;
      dbl_d    = 1'b0;

      if (state_q == ST_ARM) begin
         // Detections are dropped while arming; only the sample registers move.
         if (arm_cnt_q >= ARM_LAST) begin
            state_d = ST_IDLE;
         end
      end else if (clk_det) begin
         // Evaluate the closing window without any coincident arrival, then
         // seed the fresh window with that arrival.
         res     = eval_gate(flags_q);
         flags_d = arr;
         viol_d  = any_arr;
         state_d = any_arr ? ST_PEND : ST_IDLE;
      end else begin
         dbl_d   = |(arr & flags_q);
         flags_d = flags_q | arr;
         if (any_arr) begin
            state_d = ST_PEND;
         end
      end

      // Shift pipeline: each logical clock gets its own slot, so back-to-back
      // evaluations emerge in order.
      pipe_d = OUT_DELAY'({pipe_q, res});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ARM;
         a_q         <= '0;
         sfq_q       <= 1'b0;
         flags_q     <= '0;
         pipe_q      <= '0;
         arm_cnt_q   <= '0;
         out_q       <= 1'b0;
         out_pulse_q <= 1'b0;
         viol_q      <= 1'b0;
         dbl_q       <= 1'b0;
         ready_q     <= 1'b0;
         viol_cnt_q  <= '0;
      end else begin
         a_q         <= a_i;
         sfq_q       <= sfq_clk;
         state_q     <= state_d;
         flags_q     <= flags_d;
         pipe_q      <= pipe_d;
         if (state_q == ST_ARM) begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
         end
         ready_q     <= (state_d != ST_ARM);
         out_pulse_q <= pipe_q[OUT_DELAY-1];
         out_q       <= out_q ^ pipe_q[OUT_DELAY-1];
         viol_q      <= viol_d;
         dbl_q       <= dbl_d;
         if (viol_d && (viol_cnt_q != {CNT_W{1'b1}})) begin
            viol_cnt_q <= viol_cnt_q + CNT_W'(1);
         end
      end
   end

   assign out       = out_q;
   assign out_pulse = out_pulse_q;
   assign viol      = viol_q;
   assign dbl       = dbl_q;
   assign viol_cnt  = viol_cnt_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_basic_pulse_gate_n.sv
// ---------------------------------------------------------------------------
// Bench for basic_pulse_gate_n.  Three instances share the same stimulus:
//   cfg0: MODE 0 (XOR), OUT_DELAY 1
//   cfg1: MODE 2 (AND), OUT_DELAY 2
//   cfg2: MODE 1 (OR),  OUT_DELAY 4
// A reference model tracks per-input arrival counts per window, a queue of
// scheduled output toggle times and a violation tally.
// ---------------------------------------------------------------------------
module tb_basic_pulse_gate_n;

   localparam int N     = 2;
   localparam int BEGIN = 8;
   localparam int CNT_W = 4;
   localparam int NCFG  = 3;
   localparam int MODE_C [NCFG] = '{0, 2, 1};
   localparam int DLY_C  [NCFG] = '{1, 2, 4};
   localparam int VMAX   = (1 << CNT_W) - 1;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic [N-1:0]     a_drv = '0;
   logic             s_drv = 1'b0;

   logic [NCFG-1:0]  out_w, pulse_w, viol_w, dbl_w, ready_w;
   logic [CNT_W-1:0] vcnt_w [NCFG];

   int vectors    = 0;
   int miscompares = 0;

   // reference model state
   int           ecount;
   logic [N-1:0] m_prev_a;
   logic         m_prev_s;
   int           hits    [NCFG][N];
   int           due     [NCFG][$];
   int           toggles [NCFG];
   int           vcnt    [NCFG];
   logic         ev_viol [NCFG];
   logic         ev_dbl  [NCFG];
   logic         ev_pulse[NCFG];

   always #5 clk = ~clk;

   basic_pulse_gate_n #(.N(N), .MODE(0), .OUT_DELAY(1), .BEGIN_CYCLES(BEGIN), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst_n(rst_n), .a_i(a_drv), .sfq_clk(s_drv),
      .out(out_w[0]), .out_pulse(pulse_w[0]), .viol(viol_w[0]), .dbl(dbl_w[0]),
      .viol_cnt(vcnt_w[0]), .ready(ready_w[0]));

   basic_pulse_gate_n #(.N(N), .MODE(2), .OUT_DELAY(2), .BEGIN_CYCLES(BEGIN), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .rst_n(rst_n), .a_i(a_drv), .sfq_clk(s_drv),
      .out(out_w[1]), .out_pulse(pulse_w[1]), .viol(viol_w[1]), .dbl(dbl_w[1]),
      .viol_cnt(vcnt_w[1]), .ready(ready_w[1]));

   basic_pulse_gate_n #(.N(N), .MODE(1), .OUT_DELAY(4), .BEGIN_CYCLES(BEGIN), .CNT_W(CNT_W)) dut2 (
      .clk(clk), .rst_n(rst_n), .a_i(a_drv), .sfq_clk(s_drv),
      .out(out_w[2]), .out_pulse(pulse_w[2]), .viol(viol_w[2]), .dbl(dbl_w[2]),
      .viol_cnt(vcnt_w[2]), .ready(ready_w[2]));

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cfg%0d observed=%0h expected=%0h (t=%0t)", tag, c, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ecount   = 0;
      m_prev_a = '0;
      m_prev_s = 1'b0;
      for (int c = 0; c < NCFG; c++) begin
         for (int j = 0; j < N; j++) hits[c][j] = 0;
         due[c].delete();
         toggles[c] = 0;
         vcnt[c]    = 0;
      end
   endtask

   // Apply the rules for one posedge, given the levels the DUT just sampled.
   task automatic model_edge();
      logic [N-1:0] arr;
      logic         clkd;
      int           k;
      logic         r;
      ecount++;
      arr      = a_drv ^ m_prev_a;
      clkd     = s_drv ^ m_prev_s;
      m_prev_a = a_drv;
      m_prev_s = s_drv;
      for (int c = 0; c < NCFG; c++) begin
         ev_viol[c]  = 1'b0;
         ev_dbl[c]   = 1'b0;
         ev_pulse[c] = 1'b0;
         if (ecount > BEGIN) begin
            if (clkd) begin
               k = 0;
               for (int j = 0; j < N; j++) if (hits[c][j] > 0) k++;
               case (MODE_C[c])
                  1:       r = (k > 0);
                  2:       r = (k == N);
                  default: r = (k % 2 == 1);
               endcase
               for (int j = 0; j < N; j++) hits[c][j] = 0;
               if (r) due[c].push_back(ecount + DLY_C[c]);
               if (arr != '0) begin
                  ev_viol[c] = 1'b1;
                  if (vcnt[c] < VMAX) vcnt[c]++;
               end
               for (int j = 0; j < N; j++) if (arr[j]) hits[c][j] = 1;
            end else begin
               for (int j = 0; j < N; j++) begin
                  if (arr[j]) begin
                     if (hits[c][j] > 0) ev_dbl[c] = 1'b1;
                     hits[c][j]++;
                  end
               end
            end
         end
         if (due[c].size() > 0 && due[c][0] == ecount) begin
            void'(due[c].pop_front());
            toggles[c]++;
            ev_pulse[c] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NCFG; c++) begin
         chk("out",       c, 32'(out_w[c]),   32'(toggles[c] % 2));
         chk("out_pulse", c, 32'(pulse_w[c]), 32'(ev_pulse[c]));
         chk("viol",      c, 32'(viol_w[c]),  32'(ev_viol[c]));
         chk("dbl",       c, 32'(dbl_w[c]),   32'(ev_dbl[c]));
         chk("viol_cnt",  c, 32'(vcnt_w[c]),  32'(vcnt[c]));
         chk("ready",     c, 32'(ready_w[c]), 32'(ecount >= BEGIN));
      end
   endtask

   // One clk cycle: toggle the selected inputs, let the posedge happen, check.
   task automatic tog(input logic [N-1:0] ta, input logic ts);
      a_drv = a_drv ^ ta;
      s_drv = s_drv ^ ts;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tog('0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < NCFG; c++) begin
         chk("rst_out",   c, 32'(out_w[c]),   32'd0);
         chk("rst_pulse", c, 32'(pulse_w[c]), 32'd0);
         chk("rst_viol",  c, 32'(viol_w[c]),  32'd0);
         chk("rst_dbl",   c, 32'(dbl_w[c]),   32'd0);
         chk("rst_vcnt",  c, 32'(vcnt_w[c]),  32'd0);
         chk("rst_ready", c, 32'(ready_w[c]), 32'd0);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      do_reset();

      // arming window: toggles ignored, ready low
      tog(2'b01, 1'b0);
      tog(2'b10, 1'b1);
      tog(2'b11, 1'b1);
      tog(2'b01, 1'b0);
      tog(2'b00, 1'b1);
      tog(2'b10, 1'b0);
      tog(2'b01, 1'b1);
      tog(2'b00, 1'b0);
      idle(2);

      // single arrival then clock
      tog(2'b01, 1'b0);
      tog(2'b00, 1'b1);
      idle(5);

      // both inputs, separate cycles, then clock
      tog(2'b01, 1'b0);
      tog(2'b10, 1'b0);
      tog(2'b00, 1'b1);
      idle(5);

      // double arrival on input 1
      tog(2'b10, 1'b0);
      tog(2'b10, 1'b0);
      tog(2'b00, 1'b1);
      idle(5);

      // coincident arrival and clock, then clean clock
      tog(2'b01, 1'b1);
      tog(2'b00, 1'b1);
      idle(5);

      // clock in idle, simultaneous arrivals, back-to-back clocks
      tog(2'b00, 1'b1);
      tog(2'b11, 1'b0);
      tog(2'b00, 1'b1);
      tog(2'b11, 1'b0);
      tog(2'b00, 1'b1);
      tog(2'b00, 1'b1);
      idle(5);

      // drive the violation counter into saturation
      for (int i = 0; i < (1 << CNT_W) + 1; i++) tog(2'b01, 1'b1);
      idle(6);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [N-1:0] ta;
         logic         ts;
         ta = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3)) : '0;
         ts = ($urandom_range(0, 3) == 0);
         tog(ta, ts);
      end
      idle(6);

      // reset with a result still in the output pipeline
      tog(2'b01, 1'b0);
      tog(2'b00, 1'b1);
      do_reset();
      idle(BEGIN + 6);
      tog(2'b10, 1'b0);
      tog(2'b00, 1'b1);
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
